// File: rtl/seq_detect_if.sv
// Configuration, control, serial-bit and match-event signals between the
// stream source / event consumer (master) and seq_detect_ctrl (slave).
interface seq_detect_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               abort;
    logic               in;
    logic               in_valid;
    logic               out;
    logic               evt_valid;
    logic [CNT_W-1:0]   evt_count;
    logic               evt_ready;
    logic               evt_ovf;
    logic               busy;
    logic               done;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, abort, in, in_valid, evt_ready,
        input  out, evt_valid, evt_count, evt_ovf, busy, done
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, abort, in, in_valid, evt_ready,
        output out, evt_valid, evt_count, evt_ovf, busy, done
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector: run-time pattern, overlap modes,
// match counting to a target and a valid/ready match-event port.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic        clk,
    input logic        arst,
    seq_detect_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [MAX_LEN:0] ONE     = (MAX_LEN+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out;
    logic               r_evt_valid;
    logic [CNT_W-1:0]   r_evt_count;
    logic               r_evt_ovf;

    logic [LEN_W-1:0]   w_cfg_len;
    logic               w_sample;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_inc;
    logic [MAX_LEN:0]   w_mask_full;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_accept;

    assign w_cfg_len   = (bus.cfg_len == '0 || bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
    assign w_sample    = (r_state == S_ARMED) && bus.in_valid && !bus.abort;
    assign w_hist_nxt  = {r_hist[MAX_LEN-2:0], bus.in};
    assign w_fill_inc  = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
    assign w_mask_full = (ONE << r_len) - ONE;
    assign w_mask      = w_mask_full[MAX_LEN-1:0];
    // Fill and history both include the bit being sampled this cycle.
    assign w_match     = w_sample && (w_fill_inc >= r_len) &&
                         (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_accept    = r_evt_valid && bus.evt_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_ARMED;
            S_ARMED: if (w_match && r_target != '0 && w_cnt_inc == r_target)
                         w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pattern   <= '0;
            r_len       <= LEN_MAX;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_count <= '0;
            r_evt_ovf   <= 1'b0;
        end else if (bus.abort) begin
            // Counter and overflow flag stay readable until the next start.
            r_out       <= 1'b0;
            r_evt_valid <= 1'b0;
            r_hist      <= '0;
        end else begin
            r_out <= w_match;
            if (w_accept) r_evt_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.cfg_we) begin
                    r_pattern <= bus.cfg_pattern;
                    r_len     <= w_cfg_len;
                    r_overlap <= bus.cfg_overlap;
                    r_target  <= bus.cfg_target;
                end
                if (bus.start) begin
                    r_hist      <= '0;
                    r_fill      <= '0;
                    r_cnt       <= '0;
                    r_evt_valid <= 1'b0;
                    r_evt_ovf   <= 1'b0;
                end
            end else if (w_sample) begin
                r_hist <= w_hist_nxt;
                r_fill <= (w_match && !r_overlap) ? '0 : w_fill_inc;
                if (w_match) begin
                    r_cnt <= w_cnt_inc;
                    // An unaccepted pending event keeps its count; the new one is lost.
                    if (r_evt_valid && !bus.evt_ready) begin
                        r_evt_ovf <= 1'b1;
                    end else begin
                        r_evt_valid <= 1'b1;
                        r_evt_count <= w_cnt_inc;
                    end
                end
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.evt_valid = r_evt_valid;
    assign bus.evt_count = r_evt_count;
    assign bus.evt_ovf   = r_evt_ovf;
    assign bus.busy      = (r_state == S_ARMED);
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: expected event counts queued per matching bit,
// consumed by a monitor on every out pulse.
module tb_seq_detect_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic clk = 1'b0;
    logic arst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_q[$];

    seq_detect_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus();

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!arst && bus.out) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: out=1 evt_count=%0d, none expected", bus.evt_count);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (bus.evt_count !== CNT_W'(e)) begin
                    n_fail++;
                    $display("FAIL pulse_count: got %0d expected %0d", bus.evt_count, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b);
        bus.in = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                             input logic ov, input logic [7:0] tgt);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        bus.cfg_pattern = pat; bus.cfg_len = len; bus.cfg_overlap = ov; bus.cfg_target = tgt;
        bus.cfg_we = 1'b1; tick(); bus.cfg_we = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic check_drained(input string name);
        tick(); tick();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_pulses: %0d expected pulses not seen", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; #2;
        n_tests += 6;
        if (bus.out !== 1'b0)       begin n_fail++; $display("FAIL reset_out: got %b expected 0", bus.out); end
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid: got %b expected 0", bus.evt_valid); end
        if (bus.evt_count !== '0)   begin n_fail++; $display("FAIL reset_evt_count: got %0d expected 0", bus.evt_count); end
        if (bus.evt_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_evt_ovf: got %b expected 0", bus.evt_ovf); end
        if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tick(); arst = 1'b0; tick();
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        s = 7'b1101101;
        configure(8'b1101, 4'd4, 1'b1, 8'd0);
        n_tests++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL overlap_busy: got %b expected 1", bus.busy); end
        for (int i = 6; i >= 0; i--) begin
            if (i == 3) exp_q.push_back(1);
            if (i == 0) exp_q.push_back(2);
            send_bit(s[i]);
        end
        check_drained("overlap");
        n_tests += 2;
        if (bus.evt_ovf !== 1'b0) begin n_fail++; $display("FAIL overlap_ovf: got %b expected 0", bus.evt_ovf); end
        if (bus.done !== 1'b0)    begin n_fail++; $display("FAIL overlap_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_nonoverlap();
        logic [7:0] s;
        logic [5:0] t;
        s = 8'b11011101;
        configure(8'b1101, 4'd4, 1'b0, 8'd0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) exp_q.push_back(1);
            if (i == 0) exp_q.push_back(2);
            send_bit(s[i]);
        end
        check_drained("nonov_1101");
        t = 6'b110101;
        configure(8'b101, 4'd3, 1'b1, 8'd0);
        for (int i = 5; i >= 0; i--) begin
            if (i == 2) exp_q.push_back(1);
            if (i == 0) exp_q.push_back(2);
            send_bit(t[i]);
        end
        check_drained("ov_101");
        configure(8'b101, 4'd3, 1'b0, 8'd0);
        for (int i = 5; i >= 0; i--) begin
            if (i == 2) exp_q.push_back(1);
            send_bit(t[i]);
        end
        check_drained("nonov_101");
    endtask

    task automatic test_target();
        configure(8'b11, 4'd2, 1'b1, 8'd2);
        send_bit(1'b1);
        exp_q.push_back(1); send_bit(1'b1);
        exp_q.push_back(2); send_bit(1'b1);
        n_tests += 2;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL target_done: got %b expected 1", bus.done); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL target_busy: got %b expected 0", bus.busy); end
        send_bit(1'b1); send_bit(1'b1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n_tests++;
        if (bus.done !== 1'b1) begin n_fail++; $display("FAIL target_start_ignored: done=%b expected 1", bus.done); end
        check_drained("target");
    endtask

    task automatic test_back_to_back();
        configure(8'b11, 4'd2, 1'b1, 8'd0);
        send_bit(1'b1);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(k);
            send_bit(1'b1);
        end
        check_drained("b2b");
        n_tests++;
        if (bus.evt_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", bus.evt_ovf); end
    endtask

    task automatic test_ovf();
        bus.evt_ready = 1'b0;
        configure(8'b10, 4'd2, 1'b1, 8'd0);
        send_bit(1'b1); exp_q.push_back(1); send_bit(1'b0);
        send_bit(1'b1); exp_q.push_back(1); send_bit(1'b0);
        n_tests += 3;
        if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", bus.evt_valid); end
        if (bus.evt_count !== 8'd1) begin n_fail++; $display("FAIL ovf_count: got %0d expected 1", bus.evt_count); end
        if (bus.evt_ovf !== 1'b1)   begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.evt_ovf); end
        bus.evt_ready = 1'b1; tick();
        n_tests++;
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_accept: evt_valid=%b expected 0", bus.evt_valid); end
        send_bit(1'b1); exp_q.push_back(3); send_bit(1'b0);
        check_drained("ovf");
        n_tests++;
        if (bus.evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.evt_ovf); end
    endtask

    task automatic test_gap();
        configure(8'b1101, 4'd4, 1'b1, 8'd0);
        send_bit(1'b1);
        tick(); tick(); tick();
        send_bit(1'b1); send_bit(1'b0);
        exp_q.push_back(1); send_bit(1'b1);
        check_drained("gap");
    endtask

    task automatic test_clamp();
        logic [7:0] p;
        p = 8'b10110011;
        configure(p, 4'd0, 1'b1, 8'd0);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(1);
            send_bit(p[i]);
        end
        check_drained("clamp");
    endtask

    task automatic test_abort_priority();
        bus.evt_ready = 1'b0;
        configure(8'b10, 4'd2, 1'b1, 8'd0);
        send_bit(1'b1); exp_q.push_back(1); send_bit(1'b0);
        bus.start = 1'b1; bus.abort = 1'b1; tick();
        n_tests += 3;
        if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL abort_evt_valid: got %b expected 0", bus.evt_valid); end
        if (bus.out !== 1'b0)       begin n_fail++; $display("FAIL abort_out: got %b expected 0", bus.out); end
        tick();
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: busy=%b expected 0", bus.busy); end
        bus.start = 1'b0; bus.abort = 1'b0; bus.evt_ready = 1'b1;
        check_drained("abort");
    endtask

    task automatic test_arst();
        bus.evt_ready = 1'b0;
        configure(8'b10, 4'd2, 1'b1, 8'd0);
        send_bit(1'b1); send_bit(1'b0);
        n_tests += 2;
        if (bus.out !== 1'b1)       begin n_fail++; $display("FAIL arst_pre_out: got %b expected 1", bus.out); end
        if (bus.evt_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", bus.evt_valid); end
        #1 arst = 1'b1;
        #1;
        n_tests += 4;
        if (bus.out !== 1'b0)       begin n_fail++; $display("FAIL arst_out: got %b expected 0", bus.out); end
        if (bus.evt_valid !== 1'b0) begin n_fail++; $display("FAIL arst_evt_valid: got %b expected 0", bus.evt_valid); end
        if (bus.evt_count !== '0)   begin n_fail++; $display("FAIL arst_evt_count: got %0d expected 0", bus.evt_count); end
        if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL arst_busy: got %b expected 0", bus.busy); end
        #1 arst = 1'b0;
        bus.evt_ready = 1'b1;
        tick();
        configure(8'b10, 4'd2, 1'b1, 8'd0);
        n_tests++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL arst_rearm: busy=%b expected 1", bus.busy); end
        send_bit(1'b1); exp_q.push_back(1); send_bit(1'b0);
        check_drained("arst");
    endtask

    initial begin
        arst = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;
        bus.cfg_target = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.in = 1'b0; bus.in_valid = 1'b0; bus.evt_ready = 1'b1;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_target();
        test_back_to_back();
        test_ovf();
        test_gap();
        test_clamp();
        test_abort_priority();
        test_arst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
